// File: rtl/sipo_pkg.sv
// Shared helpers for the SIPO deserializer: counter width, frame length, parity and buffer states.
// The frame length depends on the SIPO_PARITY_EN macro (one trailing even-parity bit when defined).
package sipo_pkg;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Counter must reach WIDTH when a parity bit follows the data bits.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
`ifdef SIPO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial-in / word-out bundle of the SIPO deserializer.
// master: link/consumer side driving serial bits and ready; slave: the deserializer.
interface sipo_deser_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             parity_err;
    logic             overrun;
    logic             ovr_clr;

    modport master (
        output sin, sin_valid, dout_ready, ovr_clr,
        input  dout, dout_valid, parity_err, overrun
    );

    modport slave (
        input  sin, sin_valid, dout_ready, ovr_clr,
        output dout, dout_valid, parity_err, overrun
    );
endinterface

// File: rtl/sipo_out_buf.sv
// One-entry holding register between the shifter and the word consumer.
// Owns dout/parity_err/dout_valid and the sticky overrun flag.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             word_perr,
    input  logic             dout_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             parity_err,
    output logic             overrun
);

    buf_state_t       state_r;
    buf_state_t       state_nx_s;
    logic             accept_s;
    logic             drop_s;
    logic [WIDTH-1:0] dout_r;
    logic             perr_r;
    logic             valid_r;
    logic             ovr_r;

    // Next-state: a completion refills the buffer when it is empty or being drained this edge.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        drop_s     = 1'b0;
        case (state_r)
            BUF_EMPTY: begin
                accept_s   = load;
                state_nx_s = load ? BUF_FULL : BUF_EMPTY;
            end
            BUF_FULL: begin
                accept_s   = load & dout_ready;
                drop_s     = load & ~dout_ready;
                state_nx_s = (dout_ready & ~load) ? BUF_EMPTY : BUF_FULL;
            end
            default: begin
                state_nx_s = BUF_EMPTY;
            end
        endcase
    end

    // Holding register, valid flag and sticky overrun (a new drop beats ovr_clr).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= BUF_EMPTY;
            dout_r  <= {WIDTH{1'b0}};
            perr_r  <= 1'b0;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            valid_r <= (state_nx_s == BUF_FULL);
            if (accept_s) begin
                dout_r <= word;
                perr_r <= word_perr;
            end
            if (drop_s) begin
                ovr_r <= 1'b1;
            end else if (ovr_clr) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign dout       = dout_r;
    assign parity_err = perr_r;
    assign dout_valid = valid_r;
    assign overrun    = ovr_r;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer, LSB first; shift register and bit counter feeding sipo_out_buf.
// Optional SIPO_PARITY_EN: each frame carries one trailing even-parity bit checked on completion.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         rst,
    sipo_deser_if.slave bus
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    logic [WIDTH-1:0] sreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] word_s;
    logic             done_s;
    logic             perr_s;

    // Merge the incoming bit into its slot so a completion carries the final bit too.
    always_comb begin
        word_s = sreg_r;
        done_s = bus.sin_valid & (cnt_r == LAST_CNT);
        for (int k = 0; k < WIDTH; k++) begin
            if (cnt_r == CNT_W'(k)) begin
                word_s[k] = bus.sin;
            end else begin
                word_s[k] = sreg_r[k];
            end
        end
`ifdef SIPO_PARITY_EN
        perr_s = even_parity({{(63 - WIDTH){1'b0}}, bus.sin, sreg_r});
`else
        perr_s = 1'b0;
`endif
    end

    // Shift register and frame counter advance only on qualified bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_r <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (bus.sin_valid) begin
            sreg_r <= word_s;
            cnt_r  <= done_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end
    end

    sipo_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (done_s),
        .word       (word_s),
        .word_perr  (perr_s),
        .dout_ready (bus.dout_ready),
        .ovr_clr    (bus.ovr_clr),
        .dout       (bus.dout),
        .dout_valid (bus.dout_valid),
        .parity_err (bus.parity_err),
        .overrun    (bus.overrun)
    );

endmodule
